// File: rtl/uart_cmd_ctrl_if.sv
// Bundle of UART RX/TX handshake and byte-wide register bus signals
// seen by the command sequencer.
interface uart_cmd_ctrl_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              rx_valid_i;
    logic [7:0]        rx_byte_i;
    logic              rx_err_i;
    logic              tx_start_o;
    logic [7:0]        tx_byte_o;
    logic              tx_busy_i;
    logic              reg_wr_o;
    logic              reg_rd_o;
    logic [ADDR_W-1:0] reg_addr_o;
    logic [7:0]        reg_wdata_o;
    logic [7:0]        reg_rdata_i;
    logic              reg_ack_i;
    logic              busy_o;
    logic [7:0]        err_cnt_o;

    modport master (
        input  rx_valid_i, rx_byte_i, rx_err_i, tx_busy_i, reg_rdata_i, reg_ack_i,
        output tx_start_o, tx_byte_o, reg_wr_o, reg_rd_o, reg_addr_o, reg_wdata_o,
               busy_o, err_cnt_o
    );

    modport slave (
        output rx_valid_i, rx_byte_i, rx_err_i, tx_busy_i, reg_rdata_i, reg_ack_i,
        input  tx_start_o, tx_byte_o, reg_wr_o, reg_rd_o, reg_addr_o, reg_wdata_o,
               busy_o, err_cnt_o
    );
endinterface

// File: rtl/uart_cmd_ctrl.sv
// Parses SYNC/CMD/ADDR/[DATA] frames from UART RX, runs one register bus
// transaction per frame and schedules the ACK/NAK/read-data bytes on UART TX.
module uart_cmd_ctrl #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned TIMEOUT_CYC = 100000,
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    uart_cmd_ctrl_if.master bus
);
    localparam int unsigned TMO_W   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [7:0]  CMD_WR  = 8'h01;
    localparam logic [7:0]  CMD_RD  = 8'h02;
    localparam logic [7:0]  RSP_ACK = 8'h06;
    localparam logic [7:0]  RSP_NAK = 8'h15;
    localparam logic [7:0]  RSP_RD  = 8'h5A;

    typedef enum logic [3:0] {
        IDLE, CMD, ADDR, DATA, EXEC, WAIT_ACK, TX0, TX0_W, TX1, TX1_W
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        cmd_q, cmd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [7:0]        resp0_q, resp0_d, resp1_q, resp1_d;
    logic              two_q, two_d;
    logic              tx_start_q, tx_start_d;
    logic [7:0]        tx_byte_q, tx_byte_d;
    logic              wr_q, wr_d, rd_q, rd_d;
    logic              busy_q, busy_d;
    logic [7:0]        err_q, err_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              err_inc;
    logic              tmo_hit;

    assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

    // State and output registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            cmd_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            resp0_q    <= '0;
            resp1_q    <= '0;
            two_q      <= 1'b0;
            tx_start_q <= 1'b0;
            tx_byte_q  <= '0;
            wr_q       <= 1'b0;
            rd_q       <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= '0;
            tmo_q      <= '0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            resp0_q    <= resp0_d;
            resp1_q    <= resp1_d;
            two_q      <= two_d;
            tx_start_q <= tx_start_d;
            tx_byte_q  <= tx_byte_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
            tmo_q      <= tmo_d;
        end
    end

    // Next-state, response scheduling and error accounting
    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        resp0_d    = resp0_q;
        resp1_d    = resp1_q;
        two_d      = two_q;
        tx_start_d = 1'b0;
        tx_byte_d  = tx_byte_q;
        err_inc    = 1'b0;

        // Traffic while a transaction or response is in flight is dropped but counted once
        if ((state_q inside {EXEC, WAIT_ACK, TX0, TX0_W, TX1, TX1_W}) &&
            (bus.rx_valid_i || bus.rx_err_i)) begin
            err_inc = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (bus.rx_err_i) err_inc = 1'b1;
                if (bus.rx_valid_i && bus.rx_byte_i == SYNC_BYTE) state_d = CMD;
            end
            CMD, ADDR, DATA: begin
                if (bus.rx_err_i || (!bus.rx_valid_i && tmo_hit)) begin
                    state_d = IDLE;
                    err_inc = 1'b1;
                end else if (bus.rx_valid_i) begin
                    if (state_q == CMD) begin
                        cmd_d   = bus.rx_byte_i;
                        state_d = ADDR;
                    end else if (state_q == ADDR) begin
                        addr_d = bus.rx_byte_i[ADDR_W-1:0];
                        if (cmd_q == CMD_WR) begin
                            state_d = DATA;
                        end else if (cmd_q == CMD_RD) begin
                            state_d = EXEC;
                        end else begin
                            resp0_d = RSP_NAK;
                            two_d   = 1'b0;
                            err_inc = 1'b1;
                            state_d = TX0;
                        end
                    end else begin
                        wdata_d = bus.rx_byte_i;
                        state_d = EXEC;
                    end
                end
            end
            EXEC: state_d = WAIT_ACK;
            WAIT_ACK: begin
                if (bus.reg_ack_i) begin
                    resp0_d = (cmd_q == CMD_RD) ? RSP_RD : RSP_ACK;
                    resp1_d = bus.reg_rdata_i;
                    two_d   = (cmd_q == CMD_RD);
                    state_d = TX0;
                end else if (tmo_hit) begin
                    resp0_d = RSP_NAK;
                    two_d   = 1'b0;
                    err_inc = 1'b1;
                    state_d = TX0;
                end
            end
            TX0, TX1: begin
                if (!bus.tx_busy_i) begin
                    tx_start_d = 1'b1;
                    tx_byte_d  = (state_q == TX0) ? resp0_q : resp1_q;
                    state_d    = (state_q == TX0) ? TX0_W : TX1_W;
                end
            end
            TX0_W, TX1_W: begin
                // The start pulse is still high on the first wait cycle, covering busy latency
                if (!tx_start_q && !bus.tx_busy_i) begin
                    state_d = (state_q == TX0_W && two_q) ? TX1 : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        wr_d   = (state_d inside {EXEC, WAIT_ACK}) && (cmd_d == CMD_WR);
        rd_d   = (state_d inside {EXEC, WAIT_ACK}) && (cmd_d == CMD_RD);
        busy_d = (state_d != IDLE);
        err_d  = (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
        tmo_d  = ((state_d == state_q) && (state_q inside {CMD, ADDR, DATA, WAIT_ACK}))
                 ? tmo_q + TMO_W'(1) : '0;
    end

    assign bus.tx_start_o  = tx_start_q;
    assign bus.tx_byte_o   = tx_byte_q;
    assign bus.reg_wr_o    = wr_q;
    assign bus.reg_rd_o    = rd_q;
    assign bus.reg_addr_o  = addr_q;
    assign bus.reg_wdata_o = wdata_q;
    assign bus.busy_o      = busy_q;
    assign bus.err_cnt_o   = err_q;
endmodule
